// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: register file geometry and the dump unit state type.
package cpu_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_unit.sv
// Walks a register range through one read port and streams (addr, data) beats
// on a valid/ready interface; one done pulse per request, normal or aborted.
module regfile_dump_unit #(
    parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = cpu_pkg::REG_ADDR_W,
    parameter int unsigned DATA_W   = cpu_pkg::REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_read_register,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_is_last;
    logic              r_busy;
    logic              r_done;

    logic              w_handshake;
    logic              w_at_last;
    logic [ADDR_W-1:0] w_last_clamped;

    assign w_handshake = r_valid & dump_ready;
    assign w_at_last   = (r_idx == r_last);

    // A last index beyond the populated file is clipped so the walk stays in range.
    assign w_last_clamped = (last_addr > MAX_IDX) ? MAX_IDX : last_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_last    <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_is_last <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (first_addr <= w_last_clamped) begin
                            r_idx   <= first_addr;
                            r_last  <= w_last_clamped;
                            r_busy  <= 1'b1;
                            r_state <= READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_addr    <= r_idx;
                        r_data    <= rf_read_data;
                        r_is_last <= w_at_last;
                        r_valid   <= 1'b1;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    // An abort coinciding with a handshake still delivers that beat.
                    if ((w_handshake && r_is_last) || abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_idx   <= r_idx + ADDR_W'(1);
                        r_state <= READ;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rf_read_register = r_idx;
    assign dump_valid       = r_valid;
    assign dump_addr        = r_addr;
    assign dump_data        = r_data;
    assign dump_last        = r_is_last;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit paired with a behavioural 32x32 register file;
// beats are checked against an expected-address queue and a shadow copy of the file.
module tb_regfile_dump_unit;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          abort;
    logic [AW-1:0] rf_read_register;
    logic [DW-1:0] rf_read_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          dump_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [32];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    bit   [DW-1:0] model [32];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
    assign rf_read_data = (rf_read_register == '0) ? '0 : rf[rf_read_register];

    regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .first_addr(first_addr),
        .last_addr(last_addr), .abort(abort), .rf_read_register(rf_read_register),
        .rf_read_data(rf_read_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] expect_data(input int a);
        return (a == 0) ? '0 : model[a];
    endfunction

    task automatic write_reg(input int a, input logic [DW-1:0] v);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = v;
        tick();
        wr_en = 1'b0;
        model[a] = v;
    endtask

    // mode: 0 ready held high, 1 three stall cycles per beat, 2 random ready.
    // cyc 0 is the state right after the edge that samples start.
    task automatic run_dump(input int f, input int l, input int mode, input int abort_beat,
                            input bit abort_ready, input int wr_beat, input int wr_a,
                            input logic [DW-1:0] wr_v, input bit poke,
                            output int nbeats, output int done_at, output int first_valid_at);
        int            exp_q[$];
        int            dones = 0;
        int            stall = 0;
        bit            held = 1'b0;
        bit            abort_pending = 1'b0;
        logic [AW-1:0] h_addr = '0;
        logic [DW-1:0] h_data = '0;
        logic          h_last = 1'b0;
        nbeats = 0; done_at = -1; first_valid_at = -1;
        for (int a = f; a <= l; a++) exp_q.push_back(a);
        first_addr = AW'(f); last_addr = AW'(l); start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (abort_pending) begin
                chk("abort_valid_drop", 64'(dump_valid), 64'(0));
                chk("abort_done", 64'(done), 64'(1));
                abort_pending = 1'b0;
            end
            if (done) begin
                dones++;
                if (done_at < 0) done_at = cyc;
                chk("done_idle", 64'({busy, dump_valid}), 64'(0));
            end
            if (f > l) chk("empty_busy", 64'({busy, dump_valid}), 64'(0));
            if (dump_valid) begin
                if (first_valid_at < 0) first_valid_at = cyc;
                chk("busy_with_valid", 64'(busy), 64'(1));
                if (held) begin
                    chk("stall_addr", 64'(dump_addr), 64'(h_addr));
                    chk("stall_data", 64'(dump_data), 64'(h_data));
                    chk("stall_last", 64'(dump_last), 64'(h_last));
                end else begin
                    if (exp_q.size() == 0) chk("extra_beat", 64'(dump_valid), 64'(0));
                    else begin
                        chk("beat_addr", 64'(dump_addr), 64'(exp_q[0]));
                        chk("beat_data", 64'(dump_data), 64'(expect_data(exp_q[0])));
                        chk("beat_last", 64'(dump_last), 64'(exp_q[0] == l));
                    end
                    stall = (mode == 1) ? 3 : 0;
                end
                h_addr = dump_addr; h_data = dump_data; h_last = dump_last;
            end
            if (mode == 0) dump_ready = 1'b1;
            else if (mode == 1) begin
                dump_ready = dump_valid && (stall == 0);
                if (stall > 0) stall--;
            end else dump_ready = 1'($urandom_range(0, 1));
            abort = 1'b0;
            if (abort_beat >= 0 && dump_valid && nbeats == abort_beat && done_at < 0) begin
                abort = 1'b1;
                dump_ready = abort_ready;
                abort_pending = 1'b1;
            end
            held = dump_valid && !dump_ready && !abort;
            if (dump_valid && dump_ready) begin
                nbeats++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (wr_beat == nbeats - 1) begin
                    wr_en = 1'b1; wr_addr = AW'(wr_a); wr_data = wr_v;
                    model[wr_a] = wr_v;
                end
            end
            if (poke && cyc == 4) begin
                start = 1'b1; first_addr = '0; last_addr = AW'(31);
            end
            if (done_at >= 0 && cyc >= done_at + 3) break;
            tick();
            start = 1'b0; wr_en = 1'b0; abort = 1'b0;
        end
        dump_ready = 1'b0;
        abort = 1'b0;
        chk("done_pulses", 64'(dones), 64'(1));
    endtask

    int nb, da, fv, rf_f, rf_l;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
        first_addr = '0; last_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        chk("rst_valid", 64'(dump_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_addr", 64'(dump_addr), 64'(0));
        chk("rst_data", 64'(dump_data), 64'(0));
        chk("rst_last", 64'(dump_last), 64'(0));
        chk("rst_rdreg", 64'(rf_read_register), 64'(0));
        reset = 1'b0;
        tick();
        for (int k = 0; k < 32; k++) write_reg(k, 32'h1000_0000 + 32'(k));

        // Full dump: beat n valid at cyc 1+2n, done right after the last handshake.
        run_dump(0, 31, 0, -1, 1'b0, -1, 0, '0, 1'b0, nb, da, fv);
        chk("full_beats", 64'(nb), 64'(32));
        chk("full_first_valid", 64'(fv), 64'(1));
        chk("full_done_at", 64'(da), 64'(64));

        run_dump(5, 7, 1, -1, 1'b0, -1, 0, '0, 1'b0, nb, da, fv);
        chk("bp_beats", 64'(nb), 64'(3));

        run_dump(9, 3, 0, -1, 1'b0, -1, 0, '0, 1'b0, nb, da, fv);
        chk("empty_beats", 64'(nb), 64'(0));
        chk("empty_done_at", 64'(da), 64'(0));

        // Reg 12 is rewritten after reg 10 goes out; a start pulse while busy is ignored.
        run_dump(10, 12, 0, -1, 1'b0, 0, 12, 32'hDEAD_BEEF, 1'b1, nb, da, fv);
        chk("snap_beats", 64'(nb), 64'(3));
        tick(); tick();
        chk("snap_no_restart", 64'({busy, dump_valid}), 64'(0));

        run_dump(0, 31, 0, 4, 1'b0, -1, 0, '0, 1'b0, nb, da, fv);
        chk("abort_beats", 64'(nb), 64'(4));
        tick(); tick();
        chk("abort_idle", 64'({busy, dump_valid, done}), 64'(0));

        run_dump(2, 3, 0, 1, 1'b1, -1, 0, '0, 1'b0, nb, da, fv);
        chk("abort_last_beats", 64'(nb), 64'(2));

        run_dump(31, 31, 0, -1, 1'b0, -1, 0, '0, 1'b0, nb, da, fv);
        chk("single_beats", 64'(nb), 64'(1));
        chk("single_done_at", 64'(da), 64'(2));

        // Asynchronous reset while the first read is in flight.
        first_addr = '0; last_addr = AW'(31); start = 1'b1;
        tick();
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outputs", 64'({dump_valid, busy, done, dump_last}), 64'(0));
        chk("mid_rst_addr", 64'(dump_addr), 64'(0));
        chk("mid_rst_data", 64'(dump_data), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_done", 64'(done), 64'(0));
        end
        reset = 1'b0;
        tick();
        chk("post_rst_no_done", 64'(done), 64'(0));
        run_dump(20, 22, 0, -1, 1'b0, -1, 0, '0, 1'b0, nb, da, fv);
        chk("post_rst_beats", 64'(nb), 64'(3));

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 8; k++) write_reg(int'($urandom_range(0, 31)), $urandom());
            rf_f = int'($urandom_range(0, 31));
            rf_l = int'($urandom_range(0, 31));
            run_dump(rf_f, rf_l, 2, -1, 1'b0, -1, 0, '0, 1'b0, nb, da, fv);
            chk("rand_beats", 64'(nb), 64'((rf_f <= rf_l) ? (rf_l - rf_f + 1) : 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
